fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of a synchronous FIFO among NUM_REQ requesters. Each requester uses a valid/ready handshake. The arbiter holds a grant for a bounded burst of up to MAX_BURST beats and respects the FIFO full flag. It sits directly in front of the FIFO's write_en/data_in pins and is the only block that drives them.

---
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port among
// NUM_REQ valid/ready requesters. A grant lasts for at most MAX_BURST beats,
// and a full FIFO holds the current grant without writing.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 16,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_write_en_o,
    output logic [WIDTH-1:0]         fifo_data_in_o,
    output logic                     busy_o,
    output logic [IDW-1:0]           grant_id_o,
    output logic [15:0]              wr_count_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [BCW-1:0]   beat_q, beat_d;
    logic [15:0]      wr_q, wr_d;

    logic [IDW-1:0]   nextPtr;
    logic [IDW-1:0]   scanStart;
    logic [IDW-1:0]   candIdx;
    logic [IDW-1:0]   selIdx;
    logic             selFound;
    logic             writeEn;
    logic             doRelease;
    logic [WIDTH-1:0] lanes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lanes[i] = req_data_i[i*WIDTH +: WIDTH];
    end

    assign nextPtr = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);

    // Round-robin selection: first valid requester at or after the scan start.
    always_comb begin
        scanStart = (state_q == GRANT) ? nextPtr : rr_q;
        selFound  = 1'b0;
        selIdx    = '0;
        candIdx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            candIdx = IDW'((int'(scanStart) + k) % NUM_REQ);
            if (req_valid_i[candIdx]) begin
                selFound = 1'b1;
                selIdx   = candIdx;
            end
        end
    end

    // Next-state logic and handshake outputs for the IDLE/GRANT machine.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        beat_d      = beat_q;
        wr_d        = wr_q;
        req_ready_o = '0;
        writeEn     = 1'b0;
        doRelease   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    gnt_d   = selIdx;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                writeEn            = req_valid_i[gnt_q] & ~fifo_full_i;
                req_ready_o[gnt_q] = ~fifo_full_i;
                if (writeEn) begin
                    beat_d = beat_q + BCW'(1);
                    wr_d   = wr_q + 16'd1;
                end
                doRelease = ~req_valid_i[gnt_q]
                          | (writeEn & (beat_q == BCW'(MAX_BURST - 1)));
                if (doRelease) begin
                    rr_d = nextPtr;
                    if (selFound) begin
                        gnt_d  = selIdx;
                        beat_d = '0;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign fifo_write_en_o = writeEn;
    assign fifo_data_in_o  = lanes[gnt_q];
    assign busy_o          = (state_q == GRANT);
    assign grant_id_o      = gnt_q;
    assign wr_count_o      = wr_q;

    // State register; reset aborts any burst in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: instance A uses MAX_BURST=4, instance B
// MAX_BURST=1; both share the requester/FIFO stimulus.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  reqValid;
    logic [63:0] reqData;
    logic        fifoFull;

    logic [3:0]  readyA, readyB;
    logic        wrEnA, wrEnB;
    logic [15:0] dataA, dataB;
    logic        busyA, busyB;
    logic [1:0]  gntA, gntB;
    logic [15:0] wrCntA, wrCntB;

    int          vecCount  = 0;
    int          missCount = 0;

    int          quota    [4];
    int          sent     [4];
    int          startCyc [4];
    int          expCnt   [4];
    logic [15:0] base     [4];
    int          expWr    [$];
    int          expGid   [$];
    logic        fullQ    [$];
    bit          useB;

    fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(16), .MAX_BURST(4)) dutA (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(reqValid), .req_data_i(reqData),
        .req_ready_o(readyA), .fifo_full_i(fifoFull), .fifo_write_en_o(wrEnA),
        .fifo_data_in_o(dataA), .busy_o(busyA), .grant_id_o(gntA), .wr_count_o(wrCntA)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(16), .MAX_BURST(1)) dutB (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(reqValid), .req_data_i(reqData),
        .req_ready_o(readyB), .fifo_full_i(fifoFull), .fifo_write_en_o(wrEnB),
        .fifo_data_in_o(dataB), .busy_o(busyB), .grant_id_o(gntB), .wr_count_o(wrCntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports miscompares.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clearTraffic();
        for (int i = 0; i < 4; i++) begin
            quota[i]    = 0;
            sent[i]     = 0;
            startCyc[i] = 0;
            expCnt[i]   = 0;
        end
    endtask

    task automatic expectRun(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            expWr.push_back(id);
            expGid.push_back(id);
        end
    endtask

    task automatic expectGap(input int gid);
        expWr.push_back(-1);
        expGid.push_back(gid);
    endtask

    // Reset both instances between edges and check the reset-state outputs.
    task automatic doReset();
        rst_n    = 1'b0;
        clearTraffic();
        reqValid = '0;
        fifoFull = 1'b0;
        reqData  = 64'h0;
        reqData[15:0] = 16'h1234;
        #2;
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        checkOutput("rst_gid", 32'(gntA), 32'd0);
        checkOutput("rst_we", 32'(wrEnA), 32'd0);
        checkOutput("rst_ready", 32'(readyA), 32'd0);
        checkOutput("rst_wrcnt", 32'(wrCntA), 32'd0);
        checkOutput("rst_data_lane0", 32'(dataA), 32'h1234);
        checkOutput("rst_busyB", 32'(busyB), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Run one cycle per expected entry: drive requesters, check at mid-cycle,
    // then advance each requester whose beat was accepted.
    task automatic applyStimulus();
        int          n;
        int          e;
        int          g;
        logic        fullNow;
        logic        obsWe;
        logic [15:0] obsData;
        logic [3:0]  obsReady;
        logic [1:0]  obsGid;
        n = expWr.size();
        for (int c = 0; c < n; c++) begin
            fullNow = (c < fullQ.size()) ? fullQ[c] : 1'b0;
            for (int i = 0; i < 4; i++) begin
                reqValid[i]          = (c >= startCyc[i]) && (sent[i] < quota[i]);
                reqData[i*16 +: 16]  = base[i] + 16'(sent[i]);
            end
            fifoFull = fullNow;
            #3;
            e        = expWr[c];
            g        = expGid[c];
            obsWe    = useB ? wrEnB  : wrEnA;
            obsData  = useB ? dataB  : dataA;
            obsReady = useB ? readyB : readyA;
            obsGid   = useB ? gntB   : gntA;
            checkOutput("write_en", 32'(obsWe), 32'(e >= 0));
            if (e >= 0) begin
                checkOutput("data", 32'(obsData), 32'(base[e] + 16'(expCnt[e])));
                checkOutput("ready", 32'(obsReady), 32'(1 << e));
                expCnt[e]++;
            end else if (fullNow) begin
                checkOutput("ready_full", 32'(obsReady), 32'd0);
            end
            if (g >= 0) checkOutput("grant_id", 32'(obsGid), 32'(g));
            for (int i = 0; i < 4; i++)
                if (reqValid[i] && obsReady[i]) sent[i]++;
            @(posedge clk);
            #1;
        end
        expWr.delete();
        expGid.delete();
        fullQ.delete();
        fifoFull = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        reqValid = '0;
        reqData  = '0;
        fifoFull = 1'b0;
        useB     = 1'b0;
        base[0] = 16'h1000;
        base[1] = 16'h2000;
        base[2] = 16'h00A0;
        base[3] = 16'h4000;

        // Single requester 2, six beats: regranted after its 4-beat burst.
        doReset();
        quota[2] = 6;
        expectGap(0);
        expectRun(2, 6);
        expectGap(2);
        expectGap(0);
        applyStimulus();
        checkOutput("s1_wrcnt", 32'(wrCntA), 32'd6);
        checkOutput("s1_busy", 32'(busyA), 32'd0);

        // All four requesters valid: bursts of 4 in order, then back to 0.
        doReset();
        quota[0] = 5; quota[1] = 4; quota[2] = 4; quota[3] = 4;
        expectGap(0);
        expectRun(0, 4);
        expectRun(1, 4);
        expectRun(2, 4);
        expectRun(3, 4);
        expectRun(0, 1);
        expectGap(0);
        expectGap(0);
        applyStimulus();
        checkOutput("s2_wrcnt", 32'(wrCntA), 32'd17);

        // MAX_BURST=1 instance: requesters 1 and 3 alternate every beat.
        doReset();
        useB = 1'b1;
        quota[1] = 2; quota[3] = 2;
        expectGap(0);
        expectRun(1, 1);
        expectRun(3, 1);
        expectRun(1, 1);
        expectRun(3, 1);
        expectGap(3);
        expectGap(0);
        applyStimulus();
        checkOutput("s3_wrcnt", 32'(wrCntB), 32'd4);
        useB = 1'b0;

        // Backpressure: FIFO full for 3 cycles after two beats of requester 0.
        doReset();
        quota[0] = 6; quota[1] = 1;
        expectGap(0);
        expectRun(0, 2);
        expectGap(0);
        expectGap(0);
        expectGap(0);
        expectRun(0, 2);
        expectRun(1, 1);
        expectGap(1);
        expectRun(0, 2);
        expectGap(0);
        expectGap(0);
        for (int c = 0; c < 6; c++) fullQ.push_back(c >= 3);
        applyStimulus();
        checkOutput("s4_wrcnt", 32'(wrCntA), 32'd7);

        // Asynchronous reset during beat 2 of a burst held by requester 1.
        doReset();
        quota[1] = 4;
        expectGap(0);
        expectRun(1, 2);
        applyStimulus();
        reqValid = 4'b0010;
        reqData[31:16] = base[1] + 16'd2;
        #2;
        checkOutput("s5_pre_we", 32'(wrEnA), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_busy", 32'(busyA), 32'd0);
        checkOutput("s5_we", 32'(wrEnA), 32'd0);
        checkOutput("s5_wrcnt", 32'(wrCntA), 32'd0);
        checkOutput("s5_gid", 32'(gntA), 32'd0);
        checkOutput("s5_ready", 32'(readyA), 32'd0);
        clearTraffic();
        reqValid = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        quota[3] = 1;
        expectGap(0);
        expectRun(3, 1);
        expectGap(3);
        expectGap(0);
        applyStimulus();
        checkOutput("s5_wrcnt_after", 32'(wrCntA), 32'd1);

        // Requester 2 drops valid after 2 beats while requester 0 pends.
        doReset();
        quota[2] = 2; quota[0] = 2; startCyc[0] = 1;
        expectGap(0);
        expectRun(2, 2);
        expectGap(2);
        expectRun(0, 2);
        expectGap(0);
        expectGap(0);
        applyStimulus();
        checkOutput("s6_wrcnt", 32'(wrCntA), 32'd4);

        // Dropped requester 1 must be skipped by the pointer on the next scan.
        doReset();
        quota[1] = 1;
        expectGap(0);
        expectRun(1, 1);
        expectGap(1);
        expectGap(0);
        applyStimulus();
        clearTraffic();
        quota[1] = 1; quota[2] = 1;
        expectGap(0);
        expectRun(2, 1);
        expectGap(2);
        expectRun(1, 1);
        expectGap(1);
        expectGap(0);
        applyStimulus();
        checkOutput("s6b_wrcnt", 32'(wrCntA), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
